// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding, frame geometry and default WS2812 timing at 100 MHz.
package ws2812_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} ws_state_e;
    localparam int BITS_PER_LED = 24;
    localparam int DEF_NUM_LEDS = 8;
    localparam int DEF_T0H = 35;
    localparam int DEF_T1H = 70;
    localparam int DEF_TBIT = 125;
    localparam int DEF_RESET_CYCLES = 5000;
    function automatic int max_i(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/ws2812_tx_ctrl_if.sv
// ws2812_tx_ctrl_if: shift-register sequencing and LED data line between driver and controller.
interface ws2812_tx_ctrl_if;
    logic start;
    logic CurrentBit;
    logic LoadRegister;
    logic RotateRegisterLeft;
    logic data_out;
    logic busy;
    logic frame_done;
    modport master (
        output start, CurrentBit,
        input  LoadRegister, RotateRegisterLeft, data_out, busy, frame_done
    );
    modport slave (
        input  start, CurrentBit,
        output LoadRegister, RotateRegisterLeft, data_out, busy, frame_done
    );
endinterface

// File: rtl/ws_bit_timer.sv
// ws_bit_timer: up-counter wrapping at one of two selectable terminal values.
module ws_bit_timer #(
    parameter int W   = 4,
    parameter int TC0 = 5,
    parameter int TC1 = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         tc_sel,
    output logic [W-1:0] count,
    output logic         tc
);
    assign tc = en && count == (tc_sel ? W'(TC1) : W'(TC0));
    always_ff @(posedge clk)
        count <= (rst || clr || tc) ? '0 : (en ? count + 1'b1 : count);
endmodule

// File: rtl/ws2812_tx_ctrl.sv
// ws2812_tx_ctrl: sequences the GRB shift register and emits the WS2812 NRZ waveform.
// Define WS_AUTO_REFRESH_EN to chain frames continuously after the first start.
module ws2812_tx_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input logic               clk,
    input logic               reset,
    ws2812_tx_ctrl_if.slave   bus
);
    localparam int TW = $clog2(max_i(TBIT, RESET_CYCLES));
    localparam int LW = $clog2(NUM_LEDS + 1);
    ws_state_e state;
    logic [4:0] bit_cnt;
    logic [LW-1:0] led_cnt;
    logic [TW-1:0] timer;
    logic tc;
    logic last_bit;
    ws_bit_timer #(.W(TW), .TC0(TBIT - 1), .TC1(RESET_CYCLES - 1)) u_timer (
        .clk(clk),
        .rst(reset),
        .clr(state == LOAD),
        .en(state == SEND || state == LATCH),
        .tc_sel(state == LATCH),
        .count(timer),
        .tc(tc)
    );
    assign last_bit = led_cnt == LW'(NUM_LEDS - 1) && bit_cnt == 5'(BITS_PER_LED - 1);
    // Pulse outputs are decoded one cycle early so they line up with the timer as registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bit_cnt <= '0;
            led_cnt <= '0;
            bus.LoadRegister <= 1'b0;
            bus.RotateRegisterLeft <= 1'b0;
            bus.data_out <= 1'b0;
            bus.busy <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.LoadRegister <= 1'b0;
            bus.RotateRegisterLeft <= state == SEND && timer == TW'(TBIT - 2);
            bus.frame_done <= state == LATCH && timer == TW'(RESET_CYCLES - 2);
            bus.data_out <= state == SEND && timer < (bus.CurrentBit ? TW'(T1H) : TW'(T0H));
            case (state)
                IDLE: if (bus.start) begin
                    state <= LOAD;
                    bus.LoadRegister <= 1'b1;
                    bus.busy <= 1'b1;
                end
                LOAD: begin
                    state <= SEND;
                    bit_cnt <= '0;
                    led_cnt <= '0;
                end
                SEND: if (tc) begin
                    bit_cnt <= bit_cnt == 5'(BITS_PER_LED - 1) ? '0 : bit_cnt + 5'd1;
                    led_cnt <= led_cnt + LW'(bit_cnt == 5'(BITS_PER_LED - 1));
                    if (last_bit) state <= LATCH;
                end
                LATCH: if (tc) begin
`ifdef WS_AUTO_REFRESH_EN
                    state <= LOAD;
                    bus.LoadRegister <= 1'b1;
`else
                    state <= IDLE;
                    bus.busy <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
